tree_adder_accum_ctrl: RTL and testbench
========================================

Name: tree_adder_accum_ctrl

Overview:
Job-level sequencer around one config_binary_tree_adder instance. Per job it latches a precision mode and beat count, then streams input vectors through the tree adder, one beat per cycle. It accumulates the per-beat sums into a wide accumulator and returns one signed result over a valid/ready handshake. It sits between the operand fetch stream and the reduction result writeback.

Parameters:
P, 16, element width in bits; in halved mode each element packs two signed P/2 values
INPUTS_AMOUNT, 8, elements per input vector; power of two, at least 2
CNT_W, 8, width of the beat-count field
ACC_W, 32, accumulator and result width; must be at least 2*P

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
cfg_valid_i  in  1  job descriptor valid
cfg_ready_o  out  1  controller can accept a descriptor
cfg_beats_i  in  CNT_W  number of input vectors in the job (unsigned)
cfg_halved_i  in  1  job precision: 0 = P-bit elements, 1 = packed P/2-bit pairs
in_valid_i  in  1  input vector valid
in_ready_o  out  1  input vector accepted this cycle
in_data_i  in  INPUTS_AMOUNT x P  signed input vector (unpacked array)
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumer ready
out_data_o  out  ACC_W  signed accumulated result
busy_o  out  1  a job is in progress (state is not IDLE)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values: state=IDLE, acc=0, remaining=0, halved_q=0, out_valid_o=0, out_data_o=0, busy_o=0, cfg_ready_o=1, in_ready_o=0.
- States:
  - IDLE: cfg_ready_o=1. On a cfg handshake, latch halved_q<=cfg_halved_i, remaining<=cfg_beats_i, acc<=0.
    - If cfg_beats_i==0, go to DONE (result 0).
    - Otherwise go to ACCUM.
  - ACCUM: in_ready_o=1, cfg_ready_o=0. On each in handshake, acc<=acc+sext(tree_out) and remaining<=remaining-1.
    - When remaining==1 at the handshake, go to DONE.
    - A cycle with in_valid_i=0 does not change state.
  - DONE: out_valid_o=1, out_data_o=acc, in_ready_o=0, cfg_ready_o=0. On an out handshake, go to IDLE.
    - out_data_o stays stable while out_valid_o=1 and out_ready_i=0.
- Tree adder instance: driven by in_data_i and halved_q, never by cfg_halved_i directly, so the mode is constant for the whole job. Its output is 2*P bits, sign-extended to ACC_W.
- Arithmetic: the accumulator wraps modulo 2^ACC_W. Overflow is not flagged.
- Latency and throughput:
  - The last beat accepted at cycle t gives out_valid_o=1 at cycle t+1.
  - One beat per cycle with no bubbles.
  - A zero-beat job gives out_valid_o one cycle after cfg accept.
- No overlap: a new cfg is accepted only in IDLE, which is reached the cycle after the out handshake. Minimum job-to-job gap is one cycle.
- Simultaneous events:
  - cfg_valid_i while not in IDLE is ignored and held off by cfg_ready_o=0.
  - in_valid_i outside ACCUM is not accepted.
- Reset mid-job: drops the partial accumulation and the pending result. The next cycle is IDLE with the reset values.
- out_data_o is registered; there is no combinational path from in_data_i to out_data_o.

Decomposition:
- Package tree_acc_pkg holds:
  - the state enum typedef (IDLE, ACCUM, DONE)
  - function tree_out_w(P)=2*P
  - a sign-extension helper
- Sub-module: config_binary_tree_adder, one instance with P=P and INPUTS_AMOUNT=INPUTS_AMOUNT. No other sub-modules.

Test Plan:
- halved=0, beats=1, vector {1,2,3,4,5,6,7,8} -> out_data_o=36 one cycle after the beat; out_valid_o held until out_ready_i.
- halved=0, beats=3, vector {1,-2,3,-4,5,-6,7,-8} each beat, in_valid_i low for 2 cycles between beats 1 and 2 -> result -12; beat count unaffected by the gaps.
- halved=1, beats=2, packed pairs 1..16 (element j = {2j+1, 2j+2}) each beat -> 272. Toggling cfg_halved_i mid-job has no effect.
- beats=0 -> out_valid_o=1 with out_data_o=0 on the cycle after cfg accept; in_ready_o stays 0.
- Result stall: out_ready_i=0 for 5 cycles in DONE -> out_data_o stable, cfg_ready_o=0, in_ready_o=0. The next job is accepted the cycle after the handshake.
- rst_i pulsed after 2 of 4 beats (beats of 36) -> busy_o=0, cfg_ready_o=1 next cycle. A following 1-beat job of {1,...,8} returns 36 with no residue. Random 50-job sweep matches a software model modulo 2^ACC_W.

Source files
------------

// File: rtl/tree_acc_pkg.sv
// tree_acc_pkg: shared state type and width/sign helpers for the tree-adder accumulator
package tree_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  function automatic int tree_out_w(input int p);
    return 2 * p;
  endfunction
  // Sign-extends the low w bits of v across all 64 bits.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/config_binary_tree_adder.sv
// config_binary_tree_adder: sums a vector of P-bit or packed P/2-bit pair elements into a 2*P-bit result
module config_binary_tree_adder
  import tree_acc_pkg::*;
#(
  parameter int P = 16,
  parameter int INPUTS_AMOUNT = 8
) (
  input  logic                  halved,
  input  logic signed [P-1:0]   data [INPUTS_AMOUNT],
  output logic [tree_out_w(P)-1:0] sum
);
  localparam int TW = tree_out_w(P);
  logic [TW-1:0] t [INPUTS_AMOUNT];
  // Leaves pre-add the two halves in packed mode; the reduction halves the live width each pass.
  always_comb begin
    for (int k = 0; k < INPUTS_AMOUNT; k++)
      t[k] = halved ? TW'($signed(data[k][P-1:P/2])) + TW'($signed(data[k][P/2-1:0]))
                    : TW'(data[k]);
    for (int w = INPUTS_AMOUNT / 2; w >= 1; w = w / 2)
      for (int k = 0; k < w; k++)
        t[k] = t[2*k] + t[2*k+1];
    sum = t[0];
  end
endmodule

// File: rtl/tree_adder_accum_ctrl.sv
// tree_adder_accum_ctrl: per-job sequencer streaming vectors through the tree adder into a wide accumulator
module tree_adder_accum_ctrl
  import tree_acc_pkg::*;
#(
  parameter int P = 16,
  parameter int INPUTS_AMOUNT = 8,
  parameter int CNT_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CNT_W-1:0]    cfg_beats_i,
  input  logic                cfg_halved_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic signed [P-1:0] in_data_i [INPUTS_AMOUNT],
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_W-1:0]    out_data_o,
  output logic                busy_o
);
  localparam int TW = tree_out_w(P);
  state_e state, state_n;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic halved_q;
  logic [TW-1:0] tree_out;
  config_binary_tree_adder #(.P(P), .INPUTS_AMOUNT(INPUTS_AMOUNT)) u_tree (
    .halved(halved_q),
    .data  (in_data_i),
    .sum   (tree_out)
  );
  always_comb begin
    state_n = state;
    cfg_ready_o = state == IDLE;
    in_ready_o = state == ACCUM;
    out_valid_o = state == DONE;
    busy_o = state != IDLE;
    if (state == IDLE && cfg_valid_i) state_n = cfg_beats_i == '0 ? DONE : ACCUM;
    if (state == ACCUM && in_valid_i && remaining == CNT_W'(1)) state_n = DONE;
    if (state == DONE && out_ready_i) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      remaining <= '0;
      halved_q <= 1'b0;
    end else begin
      state <= state_n;
      if (cfg_valid_i && cfg_ready_o) begin
        halved_q <= cfg_halved_i;
        remaining <= cfg_beats_i;
        acc <= '0;
      end
      if (in_valid_i && in_ready_o) begin
        acc <= acc + ACC_W'(sext64(64'(tree_out), TW));
        remaining <= remaining - CNT_W'(1);
      end
    end
  end
  assign out_data_o = acc;
endmodule

// File: tb/tb_tree_adder_accum_ctrl.sv
// tb_tree_adder_accum_ctrl: directed jobs plus a small random sweep, checked through a result scoreboard
module tb_tree_adder_accum_ctrl;
  localparam int P = 16, N = 8, CW = 8, AW = 32;
  logic clk = 0, rst = 1;
  logic cfg_valid = 0, cfg_ready, cfg_halved = 0;
  logic [CW-1:0] cfg_beats = '0;
  logic in_valid = 0, in_ready;
  logic signed [P-1:0] in_data [N];
  logic out_valid, out_ready = 1, busy;
  logic [AW-1:0] out_data;
  int errors = 0, checks = 0;
  logic [AW-1:0] sb [$];

  tree_adder_accum_ctrl #(.P(P), .INPUTS_AMOUNT(N), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_beats_i(cfg_beats), .cfg_halved_i(cfg_halved),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops one expected value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", out_data);
      end else chk("result", 64'(out_data), 64'(sb.pop_front()));
    end
  end

  function automatic longint vsum(input bit h);
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += h ? longint'($signed(in_data[i][15:8])) + longint'($signed(in_data[i][7:0])) : longint'(in_data[i]);
    return s;
  endfunction

  task automatic cfg(input int beats, input bit h);
    int n = 0;
    while (!cfg_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cfg_wait", 64'(cfg_ready), 64'(1));
    cfg_valid = 1;
    cfg_beats = CW'(beats);
    cfg_halved = h;
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      bit hs;
      int t = 0;
      in_valid = 1;
      do begin
        hs = in_ready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 200);
      in_valid = 0;
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got no in_ready expected in_ready=1");
      end
    end
  endtask

  task automatic setv_seq();
    for (int i = 0; i < N; i++) in_data[i] = P'(i + 1);
  endtask
  task automatic setv_alt();
    for (int i = 0; i < N; i++) in_data[i] = (i % 2 == 0) ? P'(i + 1) : -P'(i + 1);
  endtask
  task automatic setv_pairs();
    for (int i = 0; i < N; i++) in_data[i] = {8'(2*i + 1), 8'(2*i + 2)};
  endtask
  task automatic setv_rand();
    for (int i = 0; i < N; i++) in_data[i] = P'($urandom);
  endtask

  initial begin
    longint exp;
    int b;
    bit h;
    int n;
    setv_seq();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rst = 0;

    // One beat of 1..8, result held until the consumer is ready.
    out_ready = 0;
    cfg(1, 0);
    send(1);
    chk("lat1_valid", 64'(out_valid), 64'(1));
    chk("lat1_busy", 64'(busy), 64'(1));
    repeat (2) begin @(posedge clk); #1; end
    chk("hold_valid", 64'(out_valid), 64'(1));
    sb.push_back(36);
    out_ready = 1;
    @(posedge clk); #1;
    chk("idle_after_out", 64'(cfg_ready), 64'(1));

    // Three alternating-sign beats with a two-cycle gap.
    setv_alt();
    cfg(3, 0);
    send(1);
    repeat (2) begin @(posedge clk); #1; end
    chk("gap_no_done", 64'(out_valid), 64'(0));
    chk("gap_in_ready", 64'(in_ready), 64'(1));
    send(2);
    sb.push_back(-12);
    chk("gap_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    // Halved mode; cfg_halved_i flips mid-job and must be ignored.
    setv_pairs();
    cfg(2, 1);
    cfg_halved = 0;
    send(2);
    sb.push_back(272);
    @(posedge clk); #1;

    // Zero-beat job.
    cfg(0, 0);
    sb.push_back(0);
    chk("zero_valid", 64'(out_valid), 64'(1));
    chk("zero_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;

    // Stalled result with a pending descriptor waiting behind it.
    setv_seq();
    out_ready = 0;
    cfg(1, 0);
    send(1);
    cfg_valid = 1;
    cfg_beats = '0;
    sb.push_back(36);
    sb.push_back(0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_data", 64'(out_data), 64'(36));
      chk("stall_cfg_ready", 64'(cfg_ready), 64'(0));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("next_cfg_ready", 64'(cfg_ready), 64'(1));
    @(posedge clk); #1;
    cfg_valid = 0;
    chk("next_job_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    // Reset after 2 of 4 beats, then a clean 1-beat job.
    cfg(4, 0);
    send(2);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    cfg(1, 0);
    send(1);
    sb.push_back(36);
    @(posedge clk); #1;

    // Random sweep against the software model.
    for (int j = 0; j < 50; j++) begin
      b = $urandom_range(0, 3);
      h = 1'($urandom_range(0, 1));
      exp = 0;
      cfg(b, h);
      for (int k = 0; k < b; k++) begin
        setv_rand();
        exp += vsum(h);
        send(1);
      end
      sb.push_back(AW'(exp));
      @(posedge clk); #1;
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
